// File: rtl/ef_psram_slave.sv
// Serial/quad PSRAM target model: sck is oversampled on clk and drives a CMD/ADDR/WAIT/RD/WR sequencer over a byte array.
// Define EF_PSRAM_SLAVE_QPI_EN to enable the 0x35/0xF5 QPI enter/exit commands; otherwise qpi_mode stays 0.
module ef_psram_slave #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_DEF = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] din,
  input  logic [3:0] wait_cycles,
  output logic [3:0] dout,
  output logic [3:0] douten,
  output logic       qpi_mode
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RD, S_WR, S_IGNORE} state_t;

  state_t            state_q;
  logic              sck_q;
  logic [4:0]        cnt_q;
  logic [7:0]        sr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              quad_q, wait_q, rd_q;
  logic [3:0]        dout_q;
  logic              qpi_on;
  logic [7:0]        mem [2**ADDR_W];

  logic              rise, fall, cmd_last, addr_last, byte_last, mem_we;
  logic [7:0]        cmd_byte, wr_byte, rd_cur;
  logic [ADDR_W-1:0] addr_shift;
  logic [4:0]        wait_tgt;

`ifdef EF_PSRAM_SLAVE_QPI_EN
  logic       qpi_q;
  logic [1:0] qpi_pend_q;  // {enter, exit}, applied when ce_n deasserts
  assign qpi_on = qpi_q;
`else
  assign qpi_on = 1'b0;
`endif

  assign rise       = sck & ~sck_q;
  assign fall       = ~sck & sck_q;
  assign cmd_byte   = qpi_on ? {sr_q[3:0], din} : {sr_q[6:0], din[0]};
  assign wr_byte    = quad_q ? {sr_q[3:0], din} : {sr_q[6:0], din[0]};
  assign addr_shift = quad_q ? {addr_q[ADDR_W-5:0], din} : {addr_q[ADDR_W-2:0], din[0]};
  assign cmd_last   = (cnt_q == (qpi_on ? 5'd1 : 5'd7));
  assign addr_last  = (cnt_q == (quad_q ? 5'd5 : 5'd23));
  assign byte_last  = (cnt_q == (quad_q ? 5'd1 : 5'd7));
  assign wait_tgt   = (wait_cycles == 4'd0) ? 5'(WAIT_DEF) : {1'b0, wait_cycles};
  assign rd_cur     = (cnt_q == 5'd0) ? mem[addr_q] : sr_q;
  assign mem_we     = ~rst & ~ce_n & (state_q == S_WR) & rise & byte_last;

  assign dout     = dout_q;
  assign douten   = (ce_n || state_q != S_RD) ? 4'b0000 : (quad_q ? 4'b1111 : 4'b0010);
  assign qpi_mode = qpi_on;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sck_q   <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      quad_q  <= 1'b0;
      wait_q  <= 1'b0;
      rd_q    <= 1'b0;
      dout_q  <= '0;
`ifdef EF_PSRAM_SLAVE_QPI_EN
      qpi_q      <= 1'b0;
      qpi_pend_q <= '0;
`endif
    end else begin
      sck_q <= sck;
      if (ce_n) begin
        state_q <= S_IDLE;
`ifdef EF_PSRAM_SLAVE_QPI_EN
        if (qpi_pend_q[1])      qpi_q <= 1'b1;
        else if (qpi_pend_q[0]) qpi_q <= 1'b0;
        qpi_pend_q <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_CMD;
            cnt_q   <= '0;
          end
          S_CMD: if (rise) begin
            sr_q  <= cmd_byte;
            cnt_q <= cnt_q + 5'd1;
            if (cmd_last) begin
              cnt_q   <= '0;
              quad_q  <= qpi_on;
              wait_q  <= 1'b0;
              rd_q    <= 1'b1;
              state_q <= S_ADDR;
              case (cmd_byte)
                8'h03: rd_q <= 1'b1;
                8'h0B: wait_q <= 1'b1;
                8'hEB: begin wait_q <= 1'b1; quad_q <= 1'b1; end
                8'h02: rd_q <= 1'b0;
                8'h38: begin rd_q <= 1'b0; quad_q <= 1'b1; end
`ifdef EF_PSRAM_SLAVE_QPI_EN
                8'h35: begin qpi_pend_q <= 2'b10; state_q <= S_IGNORE; end
                8'hF5: begin qpi_pend_q <= 2'b01; state_q <= S_IGNORE; end
`endif
                default: state_q <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: if (rise) begin
            addr_q <= addr_shift;
            cnt_q  <= cnt_q + 5'd1;
            if (addr_last) begin
              cnt_q   <= '0;
              state_q <= wait_q ? S_WAIT : (rd_q ? S_RD : S_WR);
            end
          end
          S_WAIT: if (rise) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == wait_tgt - 5'd1) begin
              cnt_q   <= '0;
              state_q <= S_RD;
            end
          end
          S_RD: if (fall) begin
            // byte is fetched from memory on its first beat, then shifted out of sr_q
            dout_q <= quad_q ? rd_cur[7:4] : {2'b00, rd_cur[7], 1'b0};
            sr_q   <= quad_q ? {rd_cur[3:0], 4'b0000} : {rd_cur[6:0], 1'b0};
            cnt_q  <= cnt_q + 5'd1;
            if (byte_last) begin
              cnt_q  <= '0;
              addr_q <= addr_q + 1'b1;
            end
          end
          S_WR: if (rise) begin
            sr_q  <= wr_byte;
            cnt_q <= cnt_q + 5'd1;
            if (byte_last) begin
              cnt_q  <= '0;
              addr_q <= addr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
